// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule definitions: word type, round constants and the
// small-sigma helpers used by the message expansion.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t shr(input word_t x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

endpackage

// File: rtl/sha256_sched_step.sv
// Combinational advance of the 16-word schedule window by LANES words.
// Lanes 2 and 3 take their sigma1 operand from the word produced two lanes below.
module sha256_sched_step
  import sha256_pkg::*;
#(
  parameter int MSGWORDS = 16,
  parameter int LANES    = 4
) (
  input  logic [MSGWORDS-1:0][31:0] win_in,
  output logic [MSGWORDS-1:0][31:0] win_out
);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    word_t x_w;
    word_t nw_w;
    if (j < 2) begin : g_win
      assign x_w = win_in[j+14];
    end else begin : g_chain
      assign x_w = g_lane[j-2].nw_w;
    end
    assign nw_w = win_in[j] + win_in[j+9] + sig0(win_in[j+1]) + sig1(x_w);
  end

  for (genvar i = 0; i < MSGWORDS; i++) begin : g_out
    if (i < MSGWORDS - LANES) begin : g_shift
      assign win_out[i] = win_in[i+LANES];
    end else begin : g_fill
      assign win_out[i] = g_lane[i-(MSGWORDS-LANES)].nw_w;
    end
  end

endmodule

// File: rtl/sha256_sched_iter.sv
// Iterative SHA-256 message scheduler: loads one padded block and streams
// K[t]+W[t], LANES words per valid/ready beat, for t = 0..ROUNDS-1.
//
// state   | meaning
// IDLE    | waiting for a block, in_ready=1
// RUN     | presenting beats; window/round advance on each accepted beat
module sha256_sched_iter
  import sha256_pkg::*;
#(
  parameter int WORDBITS = 32,
  parameter int MSGWORDS = 16,
  parameter int LANES    = 4,
  parameter int ROUNDS   = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MSGWORDS*WORDBITS-1:0] msg_in,
  output logic                         kw_valid,
  input  logic                         kw_ready,
  output logic [LANES*WORDBITS-1:0]    kw_out,
  output logic [5:0]                   kw_round,
  output logic                         kw_last,
  output logic                         busy
);

  if (WORDBITS != 32) begin : g_bad_wordbits
    $error("sha256_sched_iter: WORDBITS must be 32");
  end
  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("sha256_sched_iter: LANES must be 1, 2 or 4");
  end
  if (ROUNDS % LANES != 0) begin : g_bad_rounds
    $error("sha256_sched_iter: ROUNDS must be a multiple of LANES");
  end

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                               state;
  logic [MSGWORDS-1:0][WORDBITS-1:0]  win;
  logic [MSGWORDS-1:0][WORDBITS-1:0]  win_next;
  logic [5:0]                         round;
  logic                               run;
  logic                               take_in;
  logic                               take_kw;

  assign run      = (state == ST_RUN);
  assign busy     = run;
  assign kw_valid = run;
  assign kw_round = round;
  assign kw_last  = run && (round == 6'(ROUNDS - LANES));
  // The final beat frees the window, so a waiting block may load in the same cycle.
  assign in_ready = !run || (kw_last && kw_ready);
  assign take_in  = in_valid && in_ready;
  assign take_kw  = run && kw_ready;

  sha256_sched_step #(
    .MSGWORDS (MSGWORDS),
    .LANES    (LANES)
  ) u_step (
    .win_in  (win),
    .win_out (win_next)
  );

  always_comb begin
    kw_out = '0;
    if (run) begin
      for (int j = 0; j < LANES; j++) begin
        kw_out[j*WORDBITS +: WORDBITS] = win[j] + K[round + 6'(j)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      win   <= '0;
      round <= '0;
    end else if (take_in) begin
      state <= ST_RUN;
      win   <= msg_in;
      round <= '0;
    end else if (take_kw) begin
      if (kw_last) begin
        state <= ST_IDLE;
      end else begin
        win   <= win_next;
        round <= round + 6'(LANES);
      end
    end
  end

endmodule

// File: tb/tb_sha256_sched_iter.sv
// Bench for sha256_sched_iter: three instances (LANES = 1, 2, 4) checked
// against a plain-arithmetic FIPS 180-4 schedule model.
module tb_sha256_sched_iter;

  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         rst_n;
  logic         in_valid [3];
  logic         kw_ready [3];
  logic [511:0] msg      [3];
  logic         ir       [3];
  logic         kv       [3];
  logic         kl       [3];
  logic         bz       [3];
  logic [5:0]   kr       [3];
  logic [31:0]  o1;
  logic [63:0]  o2;
  logic [127:0] o4;

  int checks = 0;
  int errors = 0;

  sha256_sched_iter #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir[0]),
    .msg_in(msg[0]), .kw_valid(kv[0]), .kw_ready(kw_ready[0]), .kw_out(o1),
    .kw_round(kr[0]), .kw_last(kl[0]), .busy(bz[0]));

  sha256_sched_iter #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir[1]),
    .msg_in(msg[1]), .kw_valid(kv[1]), .kw_ready(kw_ready[1]), .kw_out(o2),
    .kw_round(kr[1]), .kw_last(kl[1]), .busy(bz[1]));

  sha256_sched_iter #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir[2]),
    .msg_in(msg[2]), .kw_valid(kv[2]), .kw_ready(kw_ready[2]), .kw_out(o4),
    .kw_round(kr[2]), .kw_last(kl[2]), .busy(bz[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] get_kw(input int li);
    case (li)
      0:       return {96'b0, o1};
      1:       return {64'b0, o2};
      default: return o4;
    endcase
  endfunction

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic compute_ref(input logic [511:0] blk, output logic [31:0] kw [64]);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[t*32 +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) kw[t] = w[t] + TB_K[t];
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [511:0] abc_block();
    logic [511:0] b;
    b = '0;
    b[31:0]    = 32'h61626380;
    b[511:480] = 32'h00000018;
    return b;
  endfunction

  // Presents a block from IDLE; returns at the negedge where the first beat shows.
  task automatic start_block(input int li, input logic [511:0] blk);
    @(negedge clk);
    msg[li] = blk;
    in_valid[li] = 1'b1;
    kw_ready[li] = 1'b0;
    #1;
    checks++;
    if (ir[li] !== 1'b1) begin
      errors++;
      $display("FAIL start_in_ready lanes_idx=%0d: got %b want 1", li, ir[li]);
    end
    @(negedge clk);
    in_valid[li] = 1'b0;
  endtask

  // Consumes beats from start_round to the end of the block, checking every
  // presented beat against the model. With has_next, nxt is held on in_valid
  // throughout and must load exactly on the final accept.
  task automatic run_beats(input int li, input logic [31:0] ex [64], input int start_round,
                           input int stall_pct, input bit has_next, input logic [511:0] nxt);
    int lanes;
    int r;
    int cycles;
    bit ready;
    bit stalled;
    logic [127:0] exp_v;
    logic [127:0] act;
    logic [127:0] prev_v;
    logic [5:0]   prev_r;
    lanes = 1 << li;
    r = start_round;
    cycles = 0;
    stalled = 1'b0;
    prev_v = '0;
    prev_r = '0;
    if (has_next) begin
      msg[li] = nxt;
      in_valid[li] = 1'b1;
    end
    while (r < 64) begin
      if (cycles > 64 * 40) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout lanes_idx=%0d: stuck at round %0d, want round 64", li, r);
        break;
      end
      act = get_kw(li);
      exp_v = '0;
      for (int j = 0; j < lanes; j++) exp_v[j*32 +: 32] = ex[r+j];
      checks++;
      if (kv[li] !== 1'b1 || bz[li] !== 1'b1) begin
        errors++;
        $display("FAIL beat_valid lanes_idx=%0d round=%0d: got valid=%b busy=%b want 1 1",
                 li, r, kv[li], bz[li]);
      end
      checks++;
      if (act !== exp_v || kr[li] !== 6'(r)) begin
        errors++;
        $display("FAIL beat_kw lanes_idx=%0d: got round=%0d kw=%h want round=%0d kw=%h",
                 li, kr[li], act, r, exp_v);
      end
      checks++;
      if (kl[li] !== (r == 64 - lanes)) begin
        errors++;
        $display("FAIL beat_last lanes_idx=%0d round=%0d: got %b want %b",
                 li, r, kl[li], (r == 64 - lanes));
      end
      if (stalled) begin
        checks++;
        if (act !== prev_v || kr[li] !== prev_r) begin
          errors++;
          $display("FAIL stall_hold lanes_idx=%0d: got round=%0d kw=%h want round=%0d kw=%h",
                   li, kr[li], act, prev_r, prev_v);
        end
      end
      ready = ($urandom_range(99) >= stall_pct);
      kw_ready[li] = ready;
      if (has_next) begin
        #1;
        checks++;
        if (ir[li] !== (ready && r == 64 - lanes)) begin
          errors++;
          $display("FAIL run_in_ready lanes_idx=%0d round=%0d: got %b want %b",
                   li, r, ir[li], (ready && r == 64 - lanes));
        end
      end
      prev_v = act;
      prev_r = kr[li];
      stalled = !ready;
      if (ready) r += lanes;
      cycles++;
      @(negedge clk);
    end
    kw_ready[li] = 1'b0;
    if (has_next) begin
      in_valid[li] = 1'b0;
    end else begin
      checks++;
      if (kv[li] !== 1'b0 || bz[li] !== 1'b0 || kl[li] !== 1'b0) begin
        errors++;
        $display("FAIL block_end lanes_idx=%0d: got valid=%b busy=%b last=%b want 0 0 0",
                 li, kv[li], bz[li], kl[li]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      kw_ready[i] = 1'b0;
      msg[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ir[i] !== 1'b1 || kv[i] !== 1'b0 || kl[i] !== 1'b0 || bz[i] !== 1'b0 ||
          kr[i] !== 6'd0 || get_kw(i) !== 128'b0) begin
        errors++;
        $display("FAIL reset_state lanes_idx=%0d: got rdy=%b v=%b l=%b b=%b r=%0d kw=%h want 1 0 0 0 0 0",
                 i, ir[i], kv[i], kl[i], bz[i], kr[i], get_kw(i));
      end
    end
  endtask

  task automatic test_abc_lanes4();
    logic [31:0] ex [64];
    logic [127:0] act;
    compute_ref(abc_block(), ex);
    start_block(2, abc_block());
    act = get_kw(2);
    checks++;
    if (act[31:0] !== 32'ha3ec9318 || act[63:32] !== 32'h71374491 || kr[2] !== 6'd0) begin
      errors++;
      $display("FAIL abc_beat0: got lane0=%h lane1=%h round=%0d want a3ec9318 71374491 0",
               act[31:0], act[63:32], kr[2]);
    end
    run_beats(2, ex, 0, 0, 1'b0, '0);
  endtask

  task automatic test_abc_lanes1();
    logic [31:0] ex [64];
    compute_ref(abc_block(), ex);
    start_block(0, abc_block());
    kw_ready[0] = 1'b1;
    repeat (16) @(negedge clk);
    checks++;
    if (kr[0] !== 6'd16 || o1 !== 32'h45fdcd41) begin
      errors++;
      $display("FAIL abc_round16: got round=%0d kw=%h want 16 45fdcd41", kr[0], o1);
    end
    @(negedge clk);
    checks++;
    if (kr[0] !== 6'd17 || o1 !== 32'hefcd4786) begin
      errors++;
      $display("FAIL abc_round17: got round=%0d kw=%h want 17 efcd4786", kr[0], o1);
    end
    run_beats(0, ex, 17, 0, 1'b0, '0);
  endtask

  task automatic test_stall_lanes2();
    logic [31:0] ex [64];
    logic [511:0] b;
    b = rand_block();
    compute_ref(b, ex);
    start_block(1, b);
    run_beats(1, ex, 0, 50, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exa [64];
    logic [31:0] exb [64];
    logic [511:0] a;
    logic [511:0] b;
    for (int li = 2; li >= 1; li--) begin
      a = rand_block();
      b = rand_block();
      compute_ref(a, exa);
      compute_ref(b, exb);
      start_block(li, a);
      run_beats(li, exa, 0, (li == 2) ? 0 : 30, 1'b1, b);
      run_beats(li, exb, 0, 0, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ex [64];
    logic [511:0] b;
    b = rand_block();
    start_block(2, b);
    kw_ready[2] = 1'b1;
    repeat (6) @(negedge clk);
    kw_ready[2] = 1'b0;
    checks++;
    if (kr[2] !== 6'd24 || kv[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_reset: got round=%0d valid=%b want 24 1", kr[2], kv[2]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (kv[2] !== 1'b0 || ir[2] !== 1'b1 || bz[2] !== 1'b0 || kr[2] !== 6'd0 ||
        get_kw(2) !== 128'b0) begin
      errors++;
      $display("FAIL mid_async_reset: got v=%b rdy=%b b=%b r=%0d kw=%h want 0 1 0 0 0",
               kv[2], ir[2], bz[2], kr[2], get_kw(2));
    end
    @(negedge clk);
    rst_n = 1'b1;
    kw_ready[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (kv[2] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet cycle=%0d: got valid=%b want 0", c, kv[2]);
      end
    end
    kw_ready[2] = 1'b0;
    b = rand_block();
    compute_ref(b, ex);
    start_block(2, b);
    run_beats(2, ex, 0, 0, 1'b0, '0);
  endtask

  task automatic test_random_blocks();
    logic [31:0] ex [64];
    logic [511:0] b;
    for (int li = 0; li < 3; li++) begin
      for (int n = 0; n < 30; n++) begin
        b = rand_block();
        compute_ref(b, ex);
        start_block(li, b);
        run_beats(li, ex, 0, $urandom_range(40), 1'b0, '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc_lanes4();
    test_abc_lanes1();
    test_stall_lanes2();
    test_back_to_back();
    test_reset_mid();
    test_random_blocks();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
